// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prime_pkg
//  Description : Shared types and constants for the trial-division prime
//                checker: FSM state encoding, default operand width and
//                divisor-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package prime_pkg;

  // Default operand width in bits
  localparam int PRIME_WIDTH_DEFAULT = 8;

  // State encodings, explicit 2-bit width
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_t;

  // Divisor width: the last divisor tried is the first odd value whose square
  // exceeds the operand, which is at most sqrt(2^w)+2 and fits in w/2+2 bits.
  function automatic int prime_dw(input int w);
    return w / 2 + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prime_trial_step.sv
`default_nettype none
// ============================================================================
//  Module      : prime_trial_step
//  Description : Combinational single trial-division step. Reports whether
//                d*d exceeds n (computed without truncation) and whether d
//                divides n exactly.
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_trial_step #(
  parameter int WIDTH = 8,
  parameter int DW    = 6
) (
  input  logic [WIDTH-1:0] n,
  input  logic [DW-1:0]    d,
  output logic             sq_gt,
  output logic             divides
);

  // Square is formed wide enough for both 2*WIDTH and the full d*d range
  localparam int SQW = (2 * WIDTH > 2 * DW) ? 2 * WIDTH : 2 * DW;
  // Modulo is formed wide enough to hold either operand
  localparam int MW  = (WIDTH > DW) ? WIDTH : DW;

  logic [SQW-1:0] d_sq_ext;
  logic [SQW-1:0] d_sq;
  logic [MW-1:0]  n_m;
  logic [MW-1:0]  d_m;
  logic [MW-1:0]  rem;

  // Square comparison and remainder test for the current divisor
  assign d_sq_ext = SQW'(d);
  assign d_sq     = d_sq_ext * d_sq_ext;
  assign sq_gt    = (d_sq > SQW'(n));

  assign n_m      = MW'(n);
  assign d_m      = MW'(d);
  assign rem      = (d_m != '0) ? (n_m % d_m) : n_m;
  assign divides  = (d_m != '0) && (rem == '0);

endmodule
`default_nettype wire

// File: rtl/prime_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prime_seq_checker
//  Description : Sequential primality checker using trial division by 2 and
//                then odd divisors, one divisor per clock. Valid/ready
//                handshake on both operand and result sides.
//                Optional macro PRIME_FACTOR_OUT_EN adds output 'factor'
//                (smallest divisor found for composites, else 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_seq_checker #(
  parameter int WIDTH = prime_pkg::PRIME_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_prime,
  output logic [WIDTH-1:0] cycles
`ifdef PRIME_FACTOR_OUT_EN
  ,output logic [WIDTH-1:0] factor
`endif
);

  import prime_pkg::*;

  localparam int DW = prime_dw(WIDTH);

  state_t           state;
  logic             armed;     // low in reset, high from first clock after release
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] cnt;       // CHECK cycles spent on the current operand
  logic [WIDTH-1:0] cnt_inc;
  logic [DW-1:0]    d;
  logic             sq_gt;
  logic             divides;
  logic             accept;

  prime_trial_step #(
    .WIDTH (WIDTH),
    .DW    (DW)
  ) u_step (
    .n       (n_q),
    .d       (d),
    .sq_gt   (sq_gt),
    .divides (divides)
  );

  assign in_ready  = armed && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt + WIDTH'(1);

  // Control FSM, working registers and result registers. Results are only
  // written on entry to DONE so they stay stable until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      n_q      <= '0;
      cnt      <= '0;
      d        <= DW'(2);
      is_prime <= 1'b0;
      cycles   <= '0;
`ifdef PRIME_FACTOR_OUT_EN
      factor   <= '0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            n_q <= num;
            cnt <= '0;
            d   <= DW'(2);
            if (num < WIDTH'(2)) begin
              is_prime <= 1'b0;
              cycles   <= '0;
`ifdef PRIME_FACTOR_OUT_EN
              factor   <= '0;
`endif
              state    <= S_DONE;
            end else begin
              state    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (sq_gt) begin
            is_prime <= 1'b1;
            cycles   <= cnt_inc;
`ifdef PRIME_FACTOR_OUT_EN
            factor   <= '0;
`endif
            state    <= S_DONE;
          end else if (divides) begin
            is_prime <= 1'b0;
            cycles   <= cnt_inc;
`ifdef PRIME_FACTOR_OUT_EN
            factor   <= WIDTH'(d);
`endif
            state    <= S_DONE;
          end else begin
            cnt <= cnt_inc;
            // 2 -> 3, then odd divisors only
            d   <= (d == DW'(2)) ? DW'(3) : (d + DW'(2));
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
